// File: rtl/cpu_run_ctrl.sv
// Run controller for the 16-bit pipelined core: program load, reset/enable/start
// sequencing, HALT/budget termination and cycle accounting.
module cpu_run_ctrl #(
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  input  logic        host_go,
  input  logic        host_abort,
  output logic        host_busy,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [15:0] imem_wdata,
  input  logic [15:0] imem_rdata,
  input  logic [7:0]  cpu_i_addr,
  output logic        cpu_reset_n,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic [15:0] run_cycles,
  output logic        done,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam logic [4:0] HALT_OP = 5'b00001;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        imem_we_q, imem_we_d;
  logic [7:0]  imem_addr_q, imem_addr_d;
  logic [15:0] imem_wdata_q, imem_wdata_d;

  logic load_phase;
  logic halt_seen;
  logic budget_hit;

  assign load_phase = (state_q == S_IDLE) || (state_q == S_FINISH);
  assign halt_seen  = (imem_rdata[15:11] == HALT_OP);
  // Widened so the +1 cannot wrap when the budget is the full counter range.
  assign budget_hit = ({1'b0, run_cycles_q} + 17'd1) >= {1'b0, MAX_CYCLES};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_cycles_d = run_cycles_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (host_we) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = host_addr;
          imem_wdata_d = host_wdata;
        end
        if (host_go) begin
          state_d      = S_CLEAR;
          cnt_d        = '0;
          run_cycles_d = '0;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        if (host_abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == 16'd1) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_START: begin
        state_d = host_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (host_abort) begin
          state_d = S_IDLE;
        end else begin
          run_cycles_d = run_cycles_q + 16'd1;
          if (budget_hit) begin
            run_cycles_d = MAX_CYCLES;
            timeout_d    = 1'b1;
            state_d      = S_FINISH;
          end else if (halt_seen) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (host_abort) begin
          state_d = S_IDLE;
        end else begin
          run_cycles_d = run_cycles_q + 16'd1;
          if (budget_hit) begin
            run_cycles_d = MAX_CYCLES;
            timeout_d    = 1'b1;
            state_d      = S_FINISH;
          end else if (cnt_q == 16'(DRAIN_CYCLES - 1)) begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  // The core owns memory addressing whenever it is enabled and fetching.
  always_comb begin
    host_busy   = (state_q == S_CLEAR) || (state_q == S_START) ||
                  (state_q == S_RUN)   || (state_q == S_DRAIN);
    cpu_reset_n = (state_q != S_IDLE) && (state_q != S_CLEAR);
    cpu_enable  = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
    cpu_start   = (state_q == S_START);
    imem_we     = imem_we_q;
    imem_addr   = cpu_enable ? cpu_i_addr : imem_addr_q;
    imem_wdata  = imem_wdata_q;
    run_cycles  = run_cycles_q;
    done        = done_q;
    timeout     = timeout_q;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: behavioural instruction memory and a minimal fetch-PC
// model stand in for the core; writes and run outcomes are scoreboarded.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_we = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_go = 1'b0;
  logic        host_abort = 1'b0;
  logic        host_busy;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [15:0] imem_rdata;
  logic [7:0]  cpu_i_addr;
  logic        cpu_reset_n;
  logic        cpu_enable;
  logic        cpu_start;
  logic [15:0] run_cycles;
  logic        done;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  typedef struct { logic dn; logic to; logic [15:0] cyc; int len; } run_t;
  wr_t  wr_q[$];
  run_t run_q[$];

  logic [15:0] mem [256] = '{default: 16'h0000};
  logic [7:0]  pc;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.MAX_CYCLES(16'd20), .DRAIN_CYCLES(4)) dut (
    .clock(clk), .reset(reset),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_go(host_go), .host_abort(host_abort), .host_busy(host_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .cpu_i_addr(cpu_i_addr),
    .cpu_reset_n(cpu_reset_n), .cpu_enable(cpu_enable), .cpu_start(cpu_start),
    .run_cycles(run_cycles), .done(done), .timeout(timeout)
  );

  assign imem_rdata = mem[imem_addr];
  assign cpu_i_addr = pc;

  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

  // Fetch PC: held at 0 in reset and during the start cycle; opcode 00010 is JUMP.
  always @(posedge clk) begin
    if (!cpu_reset_n) pc <= 8'd0;
    else if (cpu_enable && !cpu_start)
      pc <= (imem_rdata[15:11] == 5'b00010) ? imem_rdata[7:0] : pc + 8'd1;
  end

  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: imem_we=1 addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        if (imem_addr !== w.a || imem_wdata !== w.d) begin
          errors++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h", imem_addr, imem_wdata, w.a, w.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    wr_q.push_back('{a, d});
    tick;
    host_we = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({cpu_reset_n, cpu_enable, cpu_start, imem_we, host_busy, done, timeout} !== 7'b0 ||
        imem_addr !== 8'h00 || imem_wdata !== 16'h0000 || run_cycles !== 16'h0000) begin
      errors++;
      $display("FAIL %s: rstn=%b en=%b st=%b we=%b busy=%b done=%b to=%b addr=%h wdata=%h cyc=%0d, required all zero",
               tag, cpu_reset_n, cpu_enable, cpu_start, imem_we, host_busy, done, timeout, imem_addr, imem_wdata, run_cycles);
    end
  endtask

  task automatic go_and_wait(input logic ed, input logic et, input logic [15:0] ec, input int el,
                             input logic with_write, input logic with_abort);
    int   n;
    logic finished;
    run_t r;
    run_q.push_back('{ed, et, ec, el});
    host_go = 1'b1;
    host_abort = with_abort;
    if (with_write) begin
      host_we = 1'b1; host_addr = 8'h03; host_wdata = 16'h0123;
      wr_q.push_back('{8'h03, 16'h0123});
    end
    tick;
    host_go = 1'b0; host_abort = 1'b0; host_we = 1'b0;
    n = 0;
    finished = 1'b0;
    for (int i = 0; i < 200 && !finished; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if ({host_busy, cpu_reset_n, cpu_enable, done, timeout} !== 5'b10000 || run_cycles !== 16'd0) begin
          errors++;
          $display("FAIL clear_entry: busy=%b rstn=%b en=%b done=%b to=%b cyc=%0d, required 1 0 0 0 0 0",
                   host_busy, cpu_reset_n, cpu_enable, done, timeout, run_cycles);
        end
      end
      if (n == 2) begin
        checks++;
        if ({cpu_reset_n, cpu_start} !== 2'b00) begin
          errors++;
          $display("FAIL clear_second: rstn=%b start=%b, required 0 0", cpu_reset_n, cpu_start);
        end
      end
      if (n == 3) begin
        checks++;
        if ({cpu_reset_n, cpu_enable, cpu_start} !== 3'b111) begin
          errors++;
          $display("FAIL start_cycle: rstn/en/start=%b, required 111", {cpu_reset_n, cpu_enable, cpu_start});
        end
      end
      if (n == 4) begin
        checks++;
        if ({cpu_enable, cpu_start, imem_we} !== 3'b100 || imem_addr !== cpu_i_addr) begin
          errors++;
          $display("FAIL run_entry: en/start/we=%b addr=%h, required 100 addr=%h",
                   {cpu_enable, cpu_start, imem_we}, imem_addr, cpu_i_addr);
        end
      end
      if (!host_busy) finished = 1'b1;
      tick;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL run_end: host_busy still 1 after %0d cycles, required 0", n);
    end else begin
      r = run_q.pop_front();
      if ({done, timeout} !== {r.dn, r.to} || run_cycles !== r.cyc || (n - 1) !== r.len ||
          {cpu_reset_n, cpu_enable} !== 2'b10) begin
        errors++;
        $display("FAIL run_result: done=%b to=%b cyc=%0d busy_len=%0d rstn/en=%b, required done=%b to=%b cyc=%0d busy_len=%0d rstn/en=10",
                 done, timeout, run_cycles, n - 1, {cpu_reset_n, cpu_enable}, r.dn, r.to, r.cyc, r.len);
      end
    end
  endtask

  task automatic test_reset;
    tick; tick;
    @(negedge clk);
    check_reset_vals("reset_state");
    reset = 1'b0;
    tick;
    @(negedge clk);
    check_reset_vals("after_reset_release");
    tick;
  endtask

  task automatic test_load_and_halt;
    host_write(8'h00, 16'h4123);
    host_write(8'h01, 16'h0000);
    host_write(8'h02, 16'h0800);
    go_and_wait(1'b1, 1'b0, 16'd7, 10, 1'b1, 1'b0);
    checks++;
    if (mem[3] !== 16'h0123) begin
      errors++;
      $display("FAIL write_with_go: mem[3]=%h, required 0123", mem[3]);
    end
  endtask

  task automatic test_timeout;
    host_write(8'h00, 16'h1000);
    go_and_wait(1'b0, 1'b1, 16'd20, 23, 1'b0, 1'b0);
  endtask

  task automatic test_go_from_finish;
    host_write(8'h00, 16'h0800);
    go_and_wait(1'b1, 1'b0, 16'd5, 8, 1'b0, 1'b0);
  endtask

  task automatic test_abort_and_we;
    logic reached;
    host_write(8'h00, 16'h1000);
    host_go = 1'b1;
    tick;
    host_go = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (cpu_enable && !cpu_start && run_cycles == 16'd1) begin
        host_we = 1'b1; host_addr = 8'h10; host_wdata = 16'hBEEF;
      end
      if (run_cycles == 16'd3) host_we = 1'b0;
      if (cpu_enable && !cpu_start && run_cycles >= 16'd2) begin
        checks++;
        if (imem_we !== 1'b0) begin
          errors++;
          $display("FAIL we_in_run: imem_we=%b, required 0", imem_we);
        end
      end
      if (run_cycles == 16'd5) reached = 1'b1;
    end
    host_we = 1'b0;
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL abort_wait: run_cycles=%0d never reached 5", run_cycles);
    end
    host_abort = 1'b1;
    @(posedge clk);
    #1 host_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({host_busy, cpu_reset_n, cpu_enable, done, timeout} !== 5'b00000 || run_cycles !== 16'd5) begin
      errors++;
      $display("FAIL abort_state: busy=%b rstn=%b en=%b done=%b to=%b cyc=%0d, required 0 0 0 0 0 5",
               host_busy, cpu_reset_n, cpu_enable, done, timeout, run_cycles);
    end
    checks++;
    if (mem[8'h10] !== 16'h0000) begin
      errors++;
      $display("FAIL mem_unchanged: mem[10]=%h, required 0000", mem[8'h10]);
    end
    tick;
  endtask

  task automatic test_go_abort_idle;
    host_write(8'h00, 16'h0800);
    go_and_wait(1'b1, 1'b0, 16'd5, 8, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_drain;
    host_go = 1'b1;
    tick;
    host_go = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n < 6) tick;
    end
    checks++;
    if ({host_busy, cpu_enable} !== 2'b11 || run_cycles !== 16'd2) begin
      errors++;
      $display("FAIL drain_before_reset: busy=%b en=%b cyc=%0d, required 1 1 2", host_busy, cpu_enable, run_cycles);
    end
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset_in_drain");
    @(negedge clk);
    reset = 1'b0;
    tick;
    go_and_wait(1'b1, 1'b0, 16'd5, 8, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_load_and_halt;
    test_timeout;
    test_go_from_finish;
    test_abort_and_we;
    test_go_abort_idle;
    test_reset_in_drain;
    checks++;
    if (wr_q.size() != 0 || run_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d writes and %0d runs outstanding, required 0 0", wr_q.size(), run_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
